// File: rtl/uart_fifo.sv
// uart_fifo: 8N1-style serial transmitter and receiver with a glitch-rejecting
// start detect, a first-word-fall-through receive FIFO and sticky error flags.
module uart_fifo #(
  parameter int unsigned CLKS_PER_BIT  = 1250,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                             raw_clk,
  input  logic                             reset_n,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_strobe,
  output logic                             tx_busy,
  output logic                             tx_pin,
  input  logic                             rx_pin,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic                             rx_ready,
  input  logic                             rx_pop,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level,
  output logic                             rx_overrun,
  output logic                             rx_frame_error,
  input  logic                             error_clear
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // ---------------------------------------------------------------- TX ----
  tx_state_t              tx_state_q, tx_state_n;
  logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_n;
  logic [IDX_W-1:0]       tx_idx_q, tx_idx_n;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_n;
  logic                   tx_pin_n;
  logic                   tx_busy_n;

  // TX next state; a strobe in the final stop-bit cycle chains the next frame
  always_comb begin
    tx_state_n = tx_state_q;
    tx_cnt_n   = tx_cnt_q;
    tx_idx_n   = tx_idx_q;
    tx_shift_n = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_strobe) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_shift_n = tx_data;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift_q >> 1;
          if (tx_idx_q == IDX_LAST) begin
            tx_state_n = TX_STOP;
          end else begin
            tx_idx_n = tx_idx_q + IDX_W'(1);
          end
        end else begin
          tx_cnt_n = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_strobe) begin
            tx_state_n = TX_START;
            tx_shift_n = tx_data;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
      end
    endcase

    case (tx_state_n)
      TX_START: tx_pin_n = 1'b0;
      TX_DATA:  tx_pin_n = tx_shift_n[0];
      default:  tx_pin_n = 1'b1;
    endcase
    tx_busy_n = (tx_state_n != TX_IDLE);
  end

  // TX state and registered pin/busy outputs
  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_pin     <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_n;
      tx_cnt_q   <= tx_cnt_n;
      tx_idx_q   <= tx_idx_n;
      tx_shift_q <= tx_shift_n;
      tx_pin     <= tx_pin_n;
      tx_busy    <= tx_busy_n;
    end
  end

  // ---------------------------------------------------------------- RX ----
  logic                   rx_meta, rx_sync;
  rx_state_t              rx_state_q, rx_state_n;
  logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_n;
  logic [IDX_W-1:0]       rx_idx_q, rx_idx_n;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_n;
  logic                   rx_push_c;
  logic                   rx_ferr_c;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
    end
  end

  // RX next state: half-bit start check, then centre sampling of data and stop
  always_comb begin
    rx_state_n = rx_state_q;
    rx_cnt_n   = rx_cnt_q;
    rx_idx_n   = rx_idx_q;
    rx_shift_n = rx_shift_q;
    rx_push_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_n = '0;
          rx_idx_n = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == IDX_LAST) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_idx_n = rx_idx_q + IDX_W'(1);
          end
        end else begin
          rx_cnt_n = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_push_c  = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_ferr_c  = 1'b1;
            rx_state_n = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_n = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) begin
          rx_state_n = RX_IDLE;
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
      end
    endcase
  end

  // RX state register
  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_n;
      rx_cnt_q   <= rx_cnt_n;
      rx_idx_q   <= rx_idx_n;
      rx_shift_q <= rx_shift_n;
    end
  end

  // -------------------------------------------------------------- FIFO ----
  logic [DATA_BITS-1:0]   fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic                   pop_ok_c, push_ok_c, ovr_set_c;

  // A pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    pop_ok_c  = rx_pop && (rx_level != '0);
    push_ok_c = rx_push_c && ((rx_level != LVL_FULL) || pop_ok_c);
    ovr_set_c = rx_push_c && !push_ok_c;
  end

  // Storage array, not reset; the head is only meaningful while rx_ready
  always_ff @(posedge raw_clk) begin
    if (push_ok_c) begin
      fifo_mem[wr_ptr_q] <= rx_shift_q;
    end
  end

  // Pointers, occupancy and sticky flags (set beats clear)
  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rx_level       <= '0;
      rx_overrun     <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_c, pop_ok_c})
        2'b10:   rx_level <= rx_level + LVL_W'(1);
        2'b01:   rx_level <= rx_level - LVL_W'(1);
        default: rx_level <= rx_level;
      endcase
      if (ovr_set_c) begin
        rx_overrun <= 1'b1;
      end else if (error_clear) begin
        rx_overrun <= 1'b0;
      end
      if (rx_ferr_c) begin
        rx_frame_error <= 1'b1;
      end else if (error_clear) begin
        rx_frame_error <= 1'b0;
      end
    end
  end

  assign rx_data  = fifo_mem[rd_ptr_q];
  assign rx_ready = (rx_level != '0);

endmodule
